// File: rtl/operand_entry_pkg.sv
// ---------------------------------------------------------------------------
// operand_entry_pkg
//   Shared definitions for the keypad operand-entry block: keypad code
//   constants, the entry state enum and a small key classification helper.
// ---------------------------------------------------------------------------
package operand_entry_pkg;

    // Keypad codes 0x0-0x9 are decimal digits; the rest are commands.
    localparam logic [3:0] KEY_SIGN    = 4'hA;
    localparam logic [3:0] KEY_ENTER   = 4'hB;
    localparam logic [3:0] KEY_CLR     = 4'hC;
    localparam logic [3:0] KEY_BKSP    = 4'hD;
    localparam logic [3:0] KEY_CLR_ALL = 4'hE;
    localparam logic [3:0] KEY_NOP     = 4'hF;

    typedef enum logic {
        ST_ENTRY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    function automatic logic is_digit(input logic [3:0] key);
        return key <= 4'd9;
    endfunction

endpackage

// File: rtl/operand_entry_key_edge.sv
// ---------------------------------------------------------------------------
// key_edge
//   Registered rising-edge detector for the debounced key level.
//   Ports:
//     clk   - clock, rising edge
//     rst   - asynchronous active-low reset
//     level - debounced key-held level
//     pulse - one-cycle high on the first cycle the level is seen high
//   A key still held while reset is released produces no event: the detector
//   only arms after it has observed the level low at least once.
// ---------------------------------------------------------------------------
module key_edge
    import operand_entry_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic level,
    output logic pulse
);

    logic prev_q;
    logic prev_d;
    logic armed_q;
    logic armed_d;

    always_comb begin
        prev_d  = level;
        armed_d = armed_q | ~level;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_q  <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            prev_q  <= prev_d;
            armed_q <= armed_d;
        end
    end

    assign pulse = level & ~prev_q & armed_q;

endmodule

// File: rtl/operand_entry.sv
// ---------------------------------------------------------------------------
// operand_entry
//   Keypad-driven signed decimal operand entry. Digits build a magnitude,
//   0xA toggles the sign, 0xB commits the entry into the active slot. When
//   all N_OPS slots are committed the block holds them with out_valid until
//   the consumer accepts with out_ready.
//   Ports:
//     clk         - clock, rising edge
//     rst         - asynchronous active-low reset
//     key_value   - keypad code (0-9 digit, A sign, B enter, C clear,
//                   D backspace, E clear all, F ignored)
//     key_pressed - debounced key-held level
//     out_ready   - consumer accepts the operand set
//     operands    - flat operand array, slot i at [i*WIDTH +: WIDTH]
//     out_valid   - all slots committed and held stable
//     entry_value - signed value currently being typed
//     entry_neg   - sign flag of the current entry
//     active_op   - slot currently being entered
//     key_err     - one-cycle pulse on a rejected key
// ---------------------------------------------------------------------------
module operand_entry
    import operand_entry_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int MAX_DIGITS = 3,
    parameter int N_OPS      = 2
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic [3:0]                                    key_value,
    input  logic                                          key_pressed,
    input  logic                                          out_ready,
    output logic [N_OPS*WIDTH-1:0]                        operands,
    output logic                                          out_valid,
    output logic [WIDTH-1:0]                              entry_value,
    output logic                                          entry_neg,
    output logic [((N_OPS > 1) ? $clog2(N_OPS) : 1)-1:0]  active_op,
    output logic                                          key_err
);

    localparam int AW = (N_OPS > 1) ? $clog2(N_OPS) : 1;
    localparam int CW = $clog2(MAX_DIGITS + 1);
    localparam int XW = WIDTH + 4;

    // Largest positive magnitude representable in WIDTH-bit two's complement.
    localparam logic [XW-1:0] MAG_MAX = {5'b0, {(WIDTH-1){1'b1}}};

    function automatic logic signed [WIDTH-1:0] signed_entry(
        input logic             neg,
        input logic [WIDTH-1:0] mag
    );
        logic signed [WIDTH-1:0] m;
        m = $signed(mag);
        return neg ? -m : m;
    endfunction

    state_t                  state_q, state_d;
    logic [WIDTH-1:0]        mag_q,   mag_d;
    logic [CW-1:0]           cnt_q,   cnt_d;
    logic                    neg_q,   neg_d;
    logic [AW-1:0]           active_q, active_d;
    logic                    err_q,   err_d;
    logic signed [WIDTH-1:0] slots_q [N_OPS];
    logic signed [WIDTH-1:0] slots_d [N_OPS];

    logic                    key_ev;
    logic [XW-1:0]           mag_x10;
    logic [XW-1:0]           mag_next;
    logic                    digit_ok;
    logic signed [WIDTH-1:0] entry_val;

    key_edge u_key_edge (
        .clk   (clk),
        .rst   (rst),
        .level (key_pressed),
        .pulse (key_ev)
    );

    // Widened so the *10+d result is range-checked before any truncation.
    always_comb begin
        mag_x10  = ({4'b0, mag_q} << 3) + ({4'b0, mag_q} << 1);
        mag_next = mag_x10 + {{WIDTH{1'b0}}, key_value};
        digit_ok = (cnt_q < CW'(MAX_DIGITS)) && (mag_next <= MAG_MAX);
    end

    assign entry_val = signed_entry(neg_q, mag_q);

    always_comb begin
        state_d  = state_q;
        mag_d    = mag_q;
        cnt_d    = cnt_q;
        neg_d    = neg_q;
        active_d = active_q;
        err_d    = 1'b0;
        slots_d  = slots_q;

        if (key_ev && key_value == KEY_CLR_ALL) begin
            // Clear-all wins in both states, including a coincident handshake.
            for (int i = 0; i < N_OPS; i++) begin
                slots_d[i] = '0;
            end
            mag_d    = '0;
            cnt_d    = '0;
            neg_d    = 1'b0;
            active_d = '0;
            state_d  = ST_ENTRY;
        end else if (state_q == ST_FULL) begin
            if (key_ev && key_value != KEY_NOP) begin
                err_d = 1'b1;
            end
            if (out_ready) begin
                state_d = ST_ENTRY;
                mag_d   = '0;
                cnt_d   = '0;
                neg_d   = 1'b0;
            end
        end else if (key_ev) begin
            if (is_digit(key_value)) begin
                if (digit_ok) begin
                    mag_d = mag_next[WIDTH-1:0];
                    cnt_d = cnt_q + CW'(1);
                end else begin
                    err_d = 1'b1;
                end
            end else begin
                case (key_value)
                    KEY_SIGN: begin
                        neg_d = ~neg_q;
                    end
                    KEY_ENTER: begin
                        if (cnt_q == '0) begin
                            err_d = 1'b1;
                        end else begin
                            for (int i = 0; i < N_OPS; i++) begin
                                if (active_q == AW'(i)) begin
                                    slots_d[i] = entry_val;
                                end
                            end
                            mag_d = '0;
                            cnt_d = '0;
                            neg_d = 1'b0;
                            if (active_q == AW'(N_OPS - 1)) begin
                                state_d  = ST_FULL;
                                active_d = '0;
                            end else begin
                                active_d = active_q + AW'(1);
                            end
                        end
                    end
                    KEY_CLR: begin
                        mag_d = '0;
                        cnt_d = '0;
                        neg_d = 1'b0;
                    end
                    KEY_BKSP: begin
                        if (cnt_q != '0) begin
                            mag_d = WIDTH'(mag_q / 10);
                            cnt_d = cnt_q - CW'(1);
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_ENTRY;
            mag_q    <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            active_q <= '0;
            err_q    <= 1'b0;
            for (int i = 0; i < N_OPS; i++) begin
                slots_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            mag_q    <= mag_d;
            cnt_q    <= cnt_d;
            neg_q    <= neg_d;
            active_q <= active_d;
            err_q    <= err_d;
            slots_q  <= slots_d;
        end
    end

    for (genvar g = 0; g < N_OPS; g++) begin : g_ops
        assign operands[g*WIDTH +: WIDTH] = slots_q[g];
    end

    assign out_valid   = (state_q == ST_FULL);
    assign entry_value = entry_val;
    assign entry_neg   = neg_q;
    assign active_op   = active_q;
    assign key_err     = err_q;

endmodule

// File: tb/tb_operand_entry.sv
module tb_operand_entry;

    localparam int W    = 8;
    localparam int MAXD = 3;
    localparam int N    = 2;
    localparam int AW   = 1;

    logic             clk;
    logic             rst;
    logic [3:0]       key_value;
    logic             key_pressed;
    logic             out_ready;
    logic [N*W-1:0]   operands;
    logic             out_valid;
    logic [W-1:0]     entry_value;
    logic             entry_neg;
    logic [AW-1:0]    active_op;
    logic             key_err;

    int n_cmp;
    int n_fail;

    // Reference model state (plain integers).
    int m_slots [N];
    int m_mag;
    int m_cnt;
    bit m_neg;
    int m_active;
    bit m_full;
    bit m_err;

    operand_entry #(.WIDTH(W), .MAX_DIGITS(MAXD), .N_OPS(N)) dut (
        .clk         (clk),
        .rst         (rst),
        .key_value   (key_value),
        .key_pressed (key_pressed),
        .out_ready   (out_ready),
        .operands    (operands),
        .out_valid   (out_valid),
        .entry_value (entry_value),
        .entry_neg   (entry_neg),
        .active_op   (active_op),
        .key_err     (key_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic model_clear_entry();
        m_mag = 0;
        m_cnt = 0;
        m_neg = 0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_slots[i] = 0;
        model_clear_entry();
        m_active = 0;
        m_full   = 0;
        m_err    = 0;
    endtask

    task automatic model_key(input int k, input bit rdy);
        bit was_full;
        was_full = m_full;
        m_err = 0;
        if (k == 14) begin
            model_reset();
        end else if (was_full) begin
            if (k != 15) m_err = 1;
            if (rdy) begin
                m_full = 0;
                model_clear_entry();
            end
        end else if (k <= 9) begin
            if (m_cnt < MAXD && m_mag * 10 + k <= (1 << (W - 1)) - 1) begin
                m_mag = m_mag * 10 + k;
                m_cnt++;
            end else begin
                m_err = 1;
            end
        end else if (k == 10) begin
            m_neg = !m_neg;
        end else if (k == 11) begin
            if (m_cnt == 0) begin
                m_err = 1;
            end else begin
                m_slots[m_active] = m_neg ? -m_mag : m_mag;
                model_clear_entry();
                if (m_active == N - 1) begin
                    m_full   = 1;
                    m_active = 0;
                end else begin
                    m_active++;
                end
            end
        end else if (k == 12) begin
            model_clear_entry();
        end else if (k == 13) begin
            if (m_cnt > 0) begin
                m_mag = m_mag / 10;
                m_cnt--;
            end
        end
    endtask

    function automatic logic [W-1:0] exp_entry();
        int v;
        v = m_neg ? -m_mag : m_mag;
        return v[W-1:0];
    endfunction

    function automatic logic [N*W-1:0] exp_ops();
        logic [N*W-1:0] f;
        int v;
        f = '0;
        for (int i = 0; i < N; i++) begin
            v = m_slots[i];
            f[i*W +: W] = v[W-1:0];
        end
        return f;
    endfunction

    function automatic logic [AW-1:0] exp_active();
        int v;
        v = m_active;
        return v[AW-1:0];
    endfunction

    // One key event: level high for the detect edge, then released.
    task automatic press(input logic [3:0] k, input bit rdy);
        @(posedge clk); #1;
        key_value   = k;
        key_pressed = 1'b1;
        out_ready   = rdy;
        @(posedge clk); #1;
        key_pressed = 1'b0;
        out_ready   = 1'b0;
        model_key(int'(k), rdy);
    endtask

    task automatic handshake();
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        if (m_full) begin
            m_full = 0;
            model_clear_entry();
        end
    endtask

    task automatic do_reset();
        key_pressed = 1'b0;
        out_ready   = 1'b0;
        key_value   = 4'h0;
        rst         = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        key_pressed = 1'b0;
        out_ready = 1'b0;
        key_value = 4'h0;
        model_reset();
        #3;
        n_cmp++;
        if ({operands, out_valid, entry_value, entry_neg, active_op, key_err} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got ops=%h vld=%b ent=%h neg=%b act=%h err=%b, want all 0",
                     operands, out_valid, entry_value, entry_neg, active_op, key_err);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_commit_max();
        press(4'h1, 0); press(4'h2, 0); press(4'h7, 0);
        n_cmp++;
        if (entry_value !== 8'd127) begin
            n_fail++;
            $display("FAIL entry_127: got %h want 7f", entry_value);
        end
        press(4'hB, 0);
        n_cmp++;
        if (operands[7:0] !== 8'h7F || active_op !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL commit_127: got slot0=%h act=%b vld=%b want 7f 1 0",
                     operands[7:0], active_op, out_valid);
        end
        press(4'hE, 0);
    endtask

    task automatic test_range_err();
        press(4'h1, 0); press(4'h2, 0);
        n_cmp++;
        if (key_err !== 1'b0 || entry_value !== 8'd12) begin
            n_fail++;
            $display("FAIL entry_12: got ent=%h err=%b want 0c 0", entry_value, key_err);
        end
        press(4'h8, 0);
        n_cmp++;
        if (key_err !== 1'b1 || entry_value !== 8'd12) begin
            n_fail++;
            $display("FAIL range_err: got ent=%h err=%b want 0c 1", entry_value, key_err);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (key_err !== 1'b0) begin
            n_fail++;
            $display("FAIL err_pulse_len: got err=%b want 0", key_err);
        end
        press(4'hD, 0);
        n_cmp++;
        if (entry_value !== 8'd1 || key_err !== 1'b0) begin
            n_fail++;
            $display("FAIL backspace: got ent=%h err=%b want 01 0", entry_value, key_err);
        end
        press(4'hE, 0);
    endtask

    task automatic test_full_handshake();
        press(4'hA, 0); press(4'h4, 0); press(4'h5, 0);
        n_cmp++;
        if (entry_value !== 8'hD3 || entry_neg !== 1'b1) begin
            n_fail++;
            $display("FAIL neg_entry: got ent=%h neg=%b want d3 1", entry_value, entry_neg);
        end
        press(4'hB, 0); press(4'h3, 0); press(4'hB, 0);
        n_cmp++;
        if (operands !== 16'h03D3 || out_valid !== 1'b1 || active_op !== 1'b0) begin
            n_fail++;
            $display("FAIL full_ops: got ops=%h vld=%b act=%b want 03d3 1 0",
                     operands, out_valid, active_op);
        end
        handshake();
        n_cmp++;
        if (out_valid !== 1'b0 || active_op !== 1'b0 || operands !== 16'h03D3) begin
            n_fail++;
            $display("FAIL handshake: got vld=%b act=%b ops=%h want 0 0 03d3",
                     out_valid, active_op, operands);
        end
    endtask

    task automatic test_hold();
        press(4'hE, 0);
        @(posedge clk); #1;
        key_value = 4'h5;
        key_pressed = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        key_pressed = 1'b0;
        model_key(5, 0);
        n_cmp++;
        if (entry_value !== 8'd5) begin
            n_fail++;
            $display("FAIL hold_one_digit: got ent=%h want 05", entry_value);
        end
        press(4'hE, 0);
    endtask

    task automatic test_full_reject();
        press(4'h1, 0); press(4'hB, 0); press(4'h2, 0); press(4'hB, 0);
        press(4'h7, 0);
        n_cmp++;
        if (key_err !== 1'b1 || operands !== 16'h0201 || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL full_reject: got err=%b ops=%h vld=%b want 1 0201 1",
                     key_err, operands, out_valid);
        end
        press(4'hF, 0);
        n_cmp++;
        if (key_err !== 1'b0 || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL full_nop: got err=%b vld=%b want 0 1", key_err, out_valid);
        end
        press(4'hE, 0);
        n_cmp++;
        if (operands !== 16'h0000 || out_valid !== 1'b0 || key_err !== 1'b0) begin
            n_fail++;
            $display("FAIL full_clear_all: got ops=%h vld=%b err=%b want 0000 0 0",
                     operands, out_valid, key_err);
        end
    endtask

    task automatic test_clear_all_with_ready();
        press(4'h9, 0); press(4'hB, 0); press(4'h8, 0); press(4'hB, 0);
        press(4'hE, 1);
        n_cmp++;
        if (operands !== 16'h0000 || out_valid !== 1'b0 || active_op !== 1'b0 || entry_value !== 8'h00) begin
            n_fail++;
            $display("FAIL clear_all_ready: got ops=%h vld=%b act=%b ent=%h want 0000 0 0 00",
                     operands, out_valid, active_op, entry_value);
        end
        press(4'h9, 0); press(4'hB, 0); press(4'h8, 0); press(4'hB, 0);
        press(4'h3, 1);
        n_cmp++;
        if (key_err !== 1'b1 || out_valid !== 1'b0 || operands !== 16'h0809) begin
            n_fail++;
            $display("FAIL key_with_ready: got err=%b vld=%b ops=%h want 1 0 0809",
                     key_err, out_valid, operands);
        end
        press(4'hE, 0);
    endtask

    task automatic test_async_reset();
        press(4'hA, 0); press(4'h9, 0); press(4'h9, 0);
        n_cmp++;
        if (entry_value !== 8'h9D || entry_neg !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset_entry: got ent=%h neg=%b want 9d 1", entry_value, entry_neg);
        end
        @(posedge clk); #3;
        rst = 1'b0;
        #1;
        n_cmp++;
        if ({operands, out_valid, entry_value, entry_neg, active_op, key_err} !== '0) begin
            n_fail++;
            $display("FAIL async_reset: got ops=%h vld=%b ent=%h neg=%b act=%h err=%b want all 0",
                     operands, out_valid, entry_value, entry_neg, active_op, key_err);
        end
        model_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset_held_key();
        rst = 1'b0;
        key_value = 4'h5;
        key_pressed = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        n_cmp++;
        if (entry_value !== 8'h00 || key_err !== 1'b0) begin
            n_fail++;
            $display("FAIL held_through_reset: got ent=%h err=%b want 00 0", entry_value, key_err);
        end
        key_pressed = 1'b0;
        @(posedge clk); #1;
        press(4'h5, 0);
        n_cmp++;
        if (entry_value !== 8'h05) begin
            n_fail++;
            $display("FAIL after_rearm: got ent=%h want 05", entry_value);
        end
        press(4'hE, 0);
    endtask

    task automatic test_random();
        logic [3:0] k;
        int r;
        bit rdy;
        for (int it = 0; it < 300; it++) begin
            r = $urandom_range(0, 19);
            if (r < 10) k = 4'(r);
            else if (r < 13) k = 4'hB;
            else k = 4'($urandom_range(10, 15));
            rdy = ($urandom_range(0, 3) == 0);
            press(k, rdy);
            n_cmp++;
            if (entry_value !== exp_entry() || entry_neg !== m_neg || key_err !== m_err) begin
                n_fail++;
                $display("FAIL rnd_entry[%0d] key=%h: got ent=%h neg=%b err=%b want %h %b %b",
                         it, k, entry_value, entry_neg, key_err, exp_entry(), m_neg, m_err);
            end
            n_cmp++;
            if (operands !== exp_ops() || out_valid !== m_full || active_op !== exp_active()) begin
                n_fail++;
                $display("FAIL rnd_slots[%0d] key=%h: got ops=%h vld=%b act=%b want %h %b %b",
                         it, k, operands, out_valid, active_op, exp_ops(), m_full, exp_active());
            end
            if ($urandom_range(0, 7) == 0) begin
                handshake();
                n_cmp++;
                if (out_valid !== m_full || entry_value !== exp_entry() || operands !== exp_ops()) begin
                    n_fail++;
                    $display("FAIL rnd_handshake[%0d]: got vld=%b ent=%h ops=%h want %b %h %h",
                             it, out_valid, entry_value, operands, m_full, exp_entry(), exp_ops());
                end
            end
        end
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        test_reset();
        test_commit_max();
        test_range_err();
        test_full_handshake();
        test_hold();
        test_full_reject();
        test_clear_all_with_ready();
        test_async_reset();
        test_reset_held_key();
        do_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
